// File: rtl/hamming_weight_pkg.sv
// Shared constants and FSM state encoding for the Hamming-weight frame receiver.
package hamming_weight_pkg;

  localparam int HW_WORD_W    = 8;
  localparam int HW_NUM_WORDS = 128;
  localparam logic [HW_WORD_W-1:0] HW_START_WORD = {HW_WORD_W{1'b1}};
  localparam logic [HW_WORD_W-1:0] HW_STOP_WORD  = {HW_WORD_W{1'b0}};

  typedef logic [1:0] hw_state_t;

  localparam hw_state_t ST_IDLE = 2'd0;
  localparam hw_state_t ST_DATA = 2'd1;
  localparam hw_state_t ST_STOP = 2'd2;

endpackage

// File: rtl/hw_word_popcount.sv
// Combinational count of the set bits in one received word.
module hw_word_popcount #(
  parameter  int WORD_W = 8,
  localparam int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic [WORD_W-1:0] word,
  output logic [CNT_W-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WORD_W; i++) begin
      count = count + CNT_W'(word[i]);
    end
  end

endmodule

// File: rtl/hamming_weight_acc_rx.sv
// Framed receiver: START, NUM_WORDS data words, STOP; reports the frame popcount.
// Optional parity output is enabled with the HWRX_PARITY_EN macro.
module hamming_weight_acc_rx
  import hamming_weight_pkg::*;
#(
  parameter  int                WORD_W     = HW_WORD_W,
  parameter  int                NUM_WORDS  = HW_NUM_WORDS,
  parameter  logic [WORD_W-1:0] START_WORD = {WORD_W{1'b1}},
  parameter  logic [WORD_W-1:0] STOP_WORD  = {WORD_W{1'b0}},
  localparam int                OUT_W      = $clog2(WORD_W * NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] bit_string,
  output logic [OUT_W-1:0]  hamming_weight,
  output logic              out_valid,
  output logic              frame_err,
  output logic              busy
`ifdef HWRX_PARITY_EN
  ,
  output logic              parity
`endif
);

  localparam int PC_W  = $clog2(WORD_W + 1);
  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  hw_state_t        state_reg;
  logic [OUT_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [OUT_W-1:0] weight_reg;
  logic             out_valid_reg;
  logic             frame_err_reg;
  logic [PC_W-1:0]  word_count;

  hw_word_popcount #(
    .WORD_W(WORD_W)
  ) u_popcount (
    .word  (bit_string),
    .count (word_count)
  );

`ifdef HWRX_PARITY_EN
  logic parity_acc_reg;
  logic parity_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_acc_reg <= 1'b0;
      parity_reg     <= 1'b0;
    end else if (in_valid) begin
      case (state_reg)
        ST_IDLE: if (bit_string == START_WORD) parity_acc_reg <= 1'b0;
        ST_DATA: parity_acc_reg <= parity_acc_reg ^ (^bit_string);
        ST_STOP: if (bit_string == STOP_WORD) parity_reg <= parity_acc_reg;
        default: parity_acc_reg <= parity_acc_reg;
      endcase
    end
  end

  assign parity = parity_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      weight_reg    <= '0;
      out_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      if (in_valid) begin
        case (state_reg)
          ST_IDLE: begin
            if (bit_string == START_WORD) begin
              acc_reg   <= '0;
              cnt_reg   <= '0;
              state_reg <= ST_DATA;
            end
          end
          ST_DATA: begin
            // Delimiter values are plain data here; only the word count ends DATA.
            acc_reg <= acc_reg + OUT_W'(word_count);
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(NUM_WORDS - 1)) state_reg <= ST_STOP;
          end
          ST_STOP: begin
            if (bit_string == STOP_WORD) begin
              weight_reg    <= acc_reg;
              out_valid_reg <= 1'b1;
            end else begin
              frame_err_reg <= 1'b1;
            end
            state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign hamming_weight = weight_reg;
  assign out_valid      = out_valid_reg;
  assign frame_err      = frame_err_reg;
  assign busy           = (state_reg == ST_DATA) || (state_reg == ST_STOP);

endmodule

// File: tb/tb_hamming_weight_acc_rx.sv
// Self-checking bench for hamming_weight_acc_rx: frame table plus reset-abort sequence.
module tb_hamming_weight_acc_rx;

  localparam int NW = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  bit_string;
  logic [10:0] hamming_weight;
  logic        out_valid;
  logic        frame_err;
  logic        busy;
`ifdef HWRX_PARITY_EN
  logic        parity;
`endif

  hamming_weight_acc_rx dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .bit_string     (bit_string),
    .hamming_weight (hamming_weight),
    .out_valid      (out_valid),
    .frame_err      (frame_err),
    .busy           (busy)
`ifdef HWRX_PARITY_EN
    ,
    .parity         (parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] fill;
    int         sp_idx;
    logic [7:0] sp_val;
    logic [7:0] stop;
    bit         gap;
    bit         b2b;
    bit         err;
    int         exp_w;
  } vec_t;

  typedef struct {
    bit err;
    int w;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Each pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid || frame_err) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got out_valid=%0b frame_err=%0b, expected no pulse",
                 out_valid, frame_err);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("out_valid", {31'd0, out_valid}, {31'd0, !e.err});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.err});
        check("weight", {21'd0, hamming_weight}, e.w);
`ifdef HWRX_PARITY_EN
        check("parity", {31'd0, parity}, {31'd0, e.w[0]});
`endif
      end
    end
  end

  task automatic send(logic [7:0] w, bit gap);
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    bit_string = w;
    if (gap) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic run_frame(vec_t v);
    sb_t e;
    send(8'hFF, v.gap);
    for (int i = 0; i < NW; i++) begin
      send((i == v.sp_idx) ? v.sp_val : v.fill, v.gap);
      if (i == 0) begin
        @(negedge clk);
        check("busy_in_frame", {31'd0, busy}, 32'd1);
      end
    end
    e.err = v.err;
    e.w   = v.exp_w;
    sb.push_back(e);
    send(v.stop, v.gap);
    if (!v.b2b) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int c = 0; c < 5 && sb.size() != 0; c++) @(negedge clk);
      check("pulse_pending", sb.size(), 0);
      check("busy_after", {31'd0, busy}, 32'd0);
      check("weight_hold", {21'd0, hamming_weight}, v.exp_w);
    end
  endtask

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hFF, -1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1024};
    vecs[1] = '{8'h00,  3, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1};
    vecs[2] = '{8'h0F, -1, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b1, 1};
    vecs[3] = '{8'hA5,  0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 508};
    vecs[4] = '{8'h00,  3, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    vecs[5] = '{8'h01, 127, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 135};
    vecs[6] = '{8'h00, -1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0};
    vecs[7] = '{8'h55, -1, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 0};
    vecs[8] = '{8'h03, -1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 256};

    rst        = 1'b1;
    in_valid   = 1'b0;
    bit_string = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_weight", {21'd0, hamming_weight}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Non-start words while idle are ignored.
    send(8'h12, 1'b0);
    send(8'h00, 1'b0);
    send(8'h7F, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_ignore_busy", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 9; k++) begin
      run_frame(vecs[k]);
    end

    // Reset in the middle of a frame, then a clean all-ones frame.
    send(8'hFF, 1'b0);
    for (int i = 0; i < 60; i++) send(8'hFF, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_weight", {21'd0, hamming_weight}, 32'd0);
    repeat (3) @(negedge clk);
    run_frame(vecs[0]);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_weight_acc_rx.md
HAMMING_WEIGHT_ACC_RX -- requirements
Module: hamming_weight_acc_rx

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning width of each received word in bits.
REQ-002 SHALL have parameter NUM_WORDS, default 128, meaning number of data words per frame (frame bits = WORD_W*NUM_WORDS).
REQ-003 SHALL have parameter START_WORD, default all-ones of WORD_W, meaning frame start delimiter.
REQ-004 SHALL have parameter STOP_WORD, default all-zeros of WORD_W, meaning frame stop delimiter.
REQ-005 SHALL derive localparam OUT_W = $clog2(WORD_W*NUM_WORDS+1); this is 11 at the defaults.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 in_valid  input  1  qualifies bit_string in the current cycle.
REQ-010 bit_string  input  WORD_W  received word.
REQ-011 hamming_weight  output  OUT_W  weight of the last good frame.
REQ-012 out_valid  output  1  one-cycle pulse when hamming_weight updates.
REQ-013 frame_err  output  1  one-cycle pulse when the stop delimiter is bad.
REQ-014 busy  output  1  high while in the DATA or STOP state.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, DATA and STOP; only cycles with in_valid=1 advance it.
REQ-016 In IDLE, a word equal to START_WORD SHALL clear the accumulator and word counter and go to DATA; any other word SHALL be ignored.
REQ-017 In DATA, each word SHALL add popcount(bit_string) to the accumulator and increment the counter; after word NUM_WORDS the FSM SHALL go to STOP.
REQ-018 In DATA, START_WORD and STOP_WORD values SHALL count as ordinary data.
REQ-019 In STOP, a word equal to STOP_WORD SHALL load hamming_weight from the accumulator, pulse out_valid and return to IDLE.
REQ-020 In STOP, any other word SHALL pulse frame_err, leave hamming_weight unchanged and return to IDLE.
REQ-021 Latency: out_valid and frame_err SHALL assert in the cycle after the stop-position word is sampled, for exactly one cycle.
REQ-022 The accumulator SHALL be OUT_W bits and SHALL never wrap; the maximum value WORD_W*NUM_WORDS SHALL be representable.
REQ-023 in_valid=0 SHALL hold all state, with out_valid=0 and frame_err=0.
REQ-024 Back-to-back frames: a START_WORD in the cycle immediately after the stop word SHALL be accepted.
REQ-025 hamming_weight SHALL hold its value between good frames.

Reset
REQ-026 While rst=1 the block SHALL force: state IDLE, accumulator 0, counter 0, hamming_weight 0, out_valid 0, frame_err 0, busy 0.
REQ-027 Reset during a frame SHALL abandon the frame with no out_valid or frame_err pulse.

Configuration
REQ-028 With HWRX_PARITY_EN defined, the block SHALL add an output parity (1 bit) equal to the XOR of all frame data bits, updated together with hamming_weight; this equals the LSB of the weight.
REQ-029 Without HWRX_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package hamming_weight_pkg SHALL hold the FSM state typedef and the default WORD_W, NUM_WORDS, START_WORD and STOP_WORD constants.
REQ-031 Sub-module hw_word_popcount SHALL be a combinational popcount, parametrised by WORD_W, with output width $clog2(WORD_W+1).

Verification
REQ-032 Start 0xFF, 128×0xFF, stop 0x00 -> one-cycle out_valid, hamming_weight=1024.
REQ-033 Frame value 2^31 (byte index 3 = 0x80, all other bytes 0x00) -> hamming_weight=1.
REQ-034 After a good frame with weight 1, a frame ending in stop 0x5A -> frame_err pulse, no out_valid, hamming_weight stays 1.
REQ-035 Same 2^31 frame with in_valid low on alternate cycles -> hamming_weight=1, out_valid only after the stop word.
REQ-036 rst pulsed after data word 60, then a full all-0xFF frame -> no pulse from the aborted frame, then hamming_weight=1024.
REQ-037 With HWRX_PARITY_EN: all-0xFF frame -> parity=0; the 2^31 frame -> parity=1.
